// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver with off/on/blink/breathe modes.
module led_pattern_gen #(
    parameter int CLOCK    = 25_000_000,
    parameter int TICK     = 1000,
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = 8,
    parameter int ARG_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [3:0]          wr_chan,
    input  logic [1:0]          wr_mode,
    input  logic [ARG_BITS-1:0] wr_arg,
    output logic                wr_err,
    output logic [CHANNELS-1:0] led
);
    localparam int DIV = CLOCK / TICK;
    localparam int PW  = $clog2(DIV);
    localparam logic [PWM_BITS-1:0] DUTY_TOP = '1;

    logic [PW-1:0]       pre_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic [1:0]          mode_q [CHANNELS];
    logic [ARG_BITS-1:0] arg_q  [CHANNELS];
    logic [ARG_BITS-1:0] cnt_q  [CHANNELS];
    logic [PWM_BITS-1:0] duty_q [CHANNELS];
    logic [CHANNELS-1:0] phase_q, down_q, led_q, hit, step;
    logic                wr_ready_q, wr_err_q, tick, acc;

    // arg of 0 behaves as 1, so the terminal count is arg-1 clamped at 0
    always_comb begin
        hit  = '0;
        step = '0;
        tick = pre_q == PW'(DIV - 1);
        acc  = wr_valid && wr_ready_q;
        for (int c = 0; c < CHANNELS; c++) begin
            hit[c]  = acc && 32'(wr_chan) == c;
            step[c] = tick && mode_q[c][1] &&
                      cnt_q[c] == (arg_q[c] == '0 ? '0 : arg_q[c] - ARG_BITS'(1));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q      <= '0;
            pwm_q      <= '0;
            phase_q    <= '0;
            down_q     <= '0;
            led_q      <= '0;
            wr_ready_q <= 1'b0;
            wr_err_q   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                mode_q[c] <= '0;
                arg_q[c]  <= '0;
                cnt_q[c]  <= '0;
                duty_q[c] <= '0;
            end
        end else begin
            pre_q      <= tick ? '0 : pre_q + PW'(1);
            pwm_q      <= pwm_q + PWM_BITS'(1);
            wr_ready_q <= 1'b1;
            wr_err_q   <= acc && 32'(wr_chan) >= CHANNELS;
            for (int c = 0; c < CHANNELS; c++) begin
                led_q[c] <= mode_q[c] == 2'd3 ? pwm_q < duty_q[c] :
                            mode_q[c] == 2'd2 ? phase_q[c] : mode_q[c][0];
                if (hit[c]) begin
                    mode_q[c]  <= wr_mode;
                    arg_q[c]   <= wr_arg;
                    cnt_q[c]   <= '0;
                    phase_q[c] <= 1'b1;
                    duty_q[c]  <= '0;
                    down_q[c]  <= 1'b0;
                end else if (step[c]) begin
                    cnt_q[c]   <= '0;
                    phase_q[c] <= ~phase_q[c];
                    // direction turns on the same step that lands on an end point
                    if (mode_q[c][0]) begin
                        duty_q[c] <= down_q[c] ? duty_q[c] - PWM_BITS'(1) : duty_q[c] + PWM_BITS'(1);
                        down_q[c] <= down_q[c] ? duty_q[c] != PWM_BITS'(1)
                                               : duty_q[c] == DUTY_TOP - PWM_BITS'(1);
                    end
                end else if (tick && mode_q[c][1]) begin
                    cnt_q[c] <= cnt_q[c] + ARG_BITS'(1);
                end
            end
        end
    end

    assign led      = led_q;
    assign wr_ready = wr_ready_q;
    assign wr_err   = wr_err_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen with CLOCK=1000, TICK=100, PWM_BITS=3.
module tb_led_pattern_gen;
    localparam int CH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [3:0]    wr_chan = '0;
    logic [1:0]    wr_mode = '0;
    logic [15:0]   wr_arg = '0;
    logic          wr_err;
    logic [CH-1:0] led;

    led_pattern_gen #(
        .CLOCK(1000), .TICK(100), .CHANNELS(CH), .PWM_BITS(3), .ARG_BITS(16)
    ) dut (
        .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_chan(wr_chan), .wr_mode(wr_mode), .wr_arg(wr_arg), .wr_err(wr_err), .led(led)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          ready;
        logic          err;
        logic [CH-1:0] led;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference: edges since reset, ticks seen since each channel's last write.
    int         e;
    logic       rdy;
    logic [1:0] m_mode [CH];
    int         m_lim  [CH];
    int         m_tw   [CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int tri_duty(input int k);
        int m;
        m = k % 14;
        return m <= 7 ? m : 14 - m;
    endfunction

    function automatic logic led_of(input int c, input int pwm);
        int k;
        k = m_tw[c] / m_lim[c];
        if (m_mode[c] == 2'd0) return 1'b0;
        if (m_mode[c] == 2'd1) return 1'b1;
        if (m_mode[c] == 2'd2) return (k % 2) == 0;
        return pwm < tri_duty(k);
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [3:0] ch,
                              input logic [1:0] md, input logic [15:0] a);
        exp_t x;
        logic acc, tk;
        x = '0;
        if (r) begin
            e   = 0;
            rdy = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_mode[c] = 2'd0;
                m_lim[c]  = 1;
                m_tw[c]   = 0;
            end
        end else begin
            e++;
            tk  = (e % 10) == 0;
            acc = v && rdy;
            for (int c = 0; c < CH; c++) x.led[c] = led_of(c, (e - 1) % 8);
            x.ready = 1'b1;
            x.err   = acc && ch >= 4'(CH);
            for (int c = 0; c < CH; c++) begin
                if (acc && ch == 4'(c)) begin
                    m_mode[c] = md;
                    m_lim[c]  = a == 0 ? 1 : int'(a);
                    m_tw[c]   = 0;
                end else if (m_mode[c][1] && tk) begin
                    m_tw[c]++;
                end
            end
            rdy = 1'b1;
        end
        q.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic v, input logic [3:0] ch,
                       input logic [1:0] md, input logic [15:0] a);
        exp_t x;
        reset    = r;
        wr_valid = v;
        wr_chan  = ch;
        wr_mode  = md;
        wr_arg   = a;
        model_edge(r, v, ch, md, a);
        @(posedge clock);
        #1;
        x = q.pop_front();
        check("led", 32'(led), 32'(x.led));
        check("wr_ready", 32'(wr_ready), 32'(x.ready));
        check("wr_err", 32'(wr_err), 32'(x.err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 2'd0, 16'd0);
    endtask

    task automatic wr(input logic [3:0] ch, input logic [1:0] md, input logic [15:0] a);
        cyc(1'b0, 1'b1, ch, md, a);
    endtask

    initial begin
        logic found;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'd0, 2'd0, 16'd0);
        wr(4'd0, 2'd1, 16'd0);
        idle(2);
        wr(4'd0, 2'd1, 16'd0);
        idle(3);
        wr(4'd0, 2'd0, 16'd0);
        idle(3);
        wr(4'd1, 2'd2, 16'd3);
        idle(70);
        wr(4'd2, 2'd2, 16'd0);
        idle(25);
        wr(4'd2, 2'd3, 16'd1);
        idle(170);
        wr(4'd5, 2'd1, 16'd7);
        idle(3);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (((e + 1) % 10) == 0 && m_mode[1] == 2'd2 && ((m_tw[1] + 1) % m_lim[1]) == 0)
                found = 1'b1;
            else
                idle(1);
        end
        check("ch1_step_found", 32'(found), 32'd1);
        wr(4'd1, 2'd2, 16'd2);
        idle(50);
        cyc(1'b1, 1'b0, 4'd0, 2'd0, 16'd0);
        idle(5);
        wr(4'd3, 2'd1, 16'd0);
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
